// File: rtl/decode_stage.sv
// RV32/RV64 instruction decode stage: field split, format classification and
// sign-extended immediate, with valid/ready handshakes and an optional skid buffer.
module decode_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_itype,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Fields are plain slices of the held word, so only the word itself is stored.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        fmt_e            itype;
        logic            illegal;
    } beat_t;

    beat_t       dec;
    beat_t       out_q;
    logic        out_valid_q;
    logic        accept;
    fmt_e        fmt;
    logic        known;
    logic [31:0] imm32;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        fmt   = FMT_I;
        known = 1'b1;
        imm32 = '0;
        unique case (in_instr[6:0])
            7'b0110011:                                     fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:                         fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            7'b0111011: if (XLEN == 64) fmt = FMT_R; else known = 1'b0;
            7'b0011011: if (XLEN == 64) fmt = FMT_I; else known = 1'b0;
            default:                                        known = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11) known = 1'b0;
        if (!known) fmt = FMT_I;

        unique case (fmt)
            FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        dec.pc      = in_pc;
        dec.instr   = in_instr;
        dec.imm     = XLEN'($signed(imm32));
        dec.itype   = fmt;
        dec.illegal = !known;
    end

    assign accept = in_valid && in_ready;

    if (SKID) begin : g_skid
        beat_t skid_q;
        logic  skid_valid;

        assign in_ready = !skid_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_q       <= '0;
                skid_valid  <= 1'b0;
                skid_q      <= '0;
            end else if (flush) begin
                out_valid_q <= 1'b0;
                skid_valid  <= 1'b0;
            end else if (!out_valid_q || out_ready) begin
                // Output slot frees up: the older skid beat always goes first.
                if (skid_valid) begin
                    out_q       <= skid_q;
                    out_valid_q <= 1'b1;
                    skid_valid  <= 1'b0;
                end else begin
                    out_valid_q <= accept;
                    if (accept) out_q <= dec;
                end
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end else begin : g_single
        assign in_ready = !out_valid_q || out_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_q       <= '0;
            end else if (flush) begin
                out_valid_q <= 1'b0;
            end else if (in_ready) begin
                out_valid_q <= in_valid;
                if (accept) out_q <= dec;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_opcode  = out_q.instr[6:0];
    assign out_rd      = out_q.instr[11:7];
    assign out_funct3  = out_q.instr[14:12];
    assign out_rs1     = out_q.instr[19:15];
    assign out_rs2     = out_q.instr[24:20];
    assign out_funct7  = out_q.instr[31:25];
    assign out_imm     = out_q.imm;
    assign out_itype   = out_q.itype;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, SKID=1): decode vectors, skid
// back-pressure, flush and reset behaviour with hand-computed expectations.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_itype;
    logic            out_illegal;

    int vectors     = 0;
    int miscompares = 0;

    decode_stage #(.XLEN(XLEN), .SKID(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_funct3 (out_funct3),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_funct7 (out_funct7),
        .out_imm    (out_imm),
        .out_itype  (out_itype),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    logic [XLEN-1:0] exp_pc [6];
    logic [XLEN-1:0] held_pc;
    logic            will_accept;
    logic            will_consume;
    int              sent;
    int              received;
    int              accepted_stalled;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);

        // Two beats held (output + skid), then reset asserted mid-cycle.
        send(32'hFFF00093, 32'h0000_0040);
        send(32'hFE112E23, 32'h0000_0044);
        check("held_in_ready", in_ready, 0);
        check("held_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_opcode", out_opcode, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // Decode vectors, one per cycle with the output always draining.
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h0000_1000);
        check("addi_valid", out_valid, 1);
        check("addi_opcode", out_opcode, 7'h13);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 0);
        check("addi_itype", out_itype, 1);
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        check("addi_illegal", out_illegal, 0);
        check("addi_pc", out_pc, 32'h0000_1000);

        send(32'hFE112E23, 32'h0000_1004);
        check("sw_itype", out_itype, 2);
        check("sw_imm", out_imm, 32'hFFFF_FFFC);
        check("sw_rs1", out_rs1, 2);
        check("sw_rs2", out_rs2, 1);
        check("sw_funct3", out_funct3, 3'b010);
        check("sw_funct7", out_funct7, 7'h7F);

        send(32'hFE000CE3, 32'h0000_1008);
        check("beq_itype", out_itype, 3);
        check("beq_imm", out_imm, 32'hFFFF_FFF8);

        send(32'h800002B7, 32'h0000_100C);
        check("lui_itype", out_itype, 4);
        check("lui_imm", out_imm, 32'h8000_0000);
        check("lui_rd", out_rd, 5);

        send(32'hFFDFF06F, 32'h0000_1010);
        check("jal_itype", out_itype, 5);
        check("jal_imm", out_imm, 32'hFFFF_FFFC);

        send(32'h002081B3, 32'h0000_1014);
        check("add_itype", out_itype, 0);
        check("add_rd", out_rd, 3);
        check("add_rs2", out_rs2, 2);
        check("add_illegal", out_illegal, 0);

        // Illegal encodings fall back to I format with the I-immediate.
        send(32'h0000_0000, 32'h0000_1018);
        check("zero_illegal", out_illegal, 1);
        check("zero_itype", out_itype, 1);
        send(32'h0000_007F, 32'h0000_101C);
        check("7f_illegal", out_illegal, 1);
        check("7f_itype", out_itype, 1);
        send(32'h8000_007F, 32'h0000_1020);
        check("7f_imm", out_imm, 32'hFFFF_F800);
        send(32'h0000_003B, 32'h0000_1024);
        check("w_op_illegal_rv32", out_illegal, 1);
        check("w_op_itype_rv32", out_itype, 1);
        send(32'h0000_0010, 32'h0000_1028);
        check("low_bits_illegal", out_illegal, 1);
        tick();
        check("drained", out_valid, 0);

        // Six beats against a 3-cycle output stall.
        for (int i = 0; i < 6; i++) exp_pc[i] = 32'h0000_2000 + 32'(i * 4);
        sent = 0;
        received = 0;
        accepted_stalled = 0;
        for (int c = 0; c < 40 && received < 6; c++) begin
            out_ready = (c >= 3);
            in_valid  = (sent < 6);
            in_instr  = 32'h0000_0013 | (32'(sent) << 20);
            in_pc     = (sent < 6) ? exp_pc[sent] : '0;
            will_accept  = in_valid && in_ready;
            will_consume = out_valid && out_ready;
            held_pc      = out_pc;
            tick();
            if (will_accept) begin
                sent++;
                if (c < 3) accepted_stalled++;
            end
            if (will_consume) begin
                check("stream_order", held_pc, exp_pc[received]);
                received++;
            end
            if (c == 1 || c == 2) check("stall_hold_pc", out_pc, exp_pc[0]);
            if (c == 2) begin
                check("stall_accepted", accepted_stalled, 2);
                check("stall_in_ready", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        check("stream_received", received, 6);
        tick();
        check("stream_no_dup", out_valid, 0);

        // Full throughput with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h0000_0013;
            in_pc    = 32'h0000_3000 + 32'(i * 4);
            tick();
            check("tput_valid", out_valid, 1);
            check("tput_pc", out_pc, 32'h0000_3000 + 32'(i * 4));
            check("tput_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();

        // Flush with output and skid occupied and a third beat offered.
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h0000_4000);
        send(32'h0020_0093, 32'h0000_4004);
        check("pre_flush_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_instr = 32'h0030_0093;
        in_pc    = 32'h0000_4008;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_ghost", out_valid, 0);
        end

        // A beat offered to an empty stage during flush is discarded.
        in_valid = 1'b1;
        in_instr = 32'h0040_0093;
        in_pc    = 32'h0000_400C;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_incoming", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
